// File: rtl/uart_tx_byte_if.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_byte_if                                              |
// | Description : Byte-request / completion handshake between a bus master    |
// |               and the uart_tx_byte serializer.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface uart_tx_byte_if;
  logic [7:0] bus_data;         // byte to transmit, valid with bus_data_flag
  logic       bus_data_flag;    // one-cycle transmit request
  logic       bus_send_finish;  // one-cycle pulse after the stop bit
  logic       busy;             // frame in progress

  modport master (
    output bus_data,
    output bus_data_flag,
    input  bus_send_finish,
    input  busy
  );

  modport slave (
    input  bus_data,
    input  bus_data_flag,
    output bus_send_finish,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_byte                                                 |
// | Description : Single-byte UART transmitter, LSB first, 1 start / 1 stop.  |
// |               Define UART_TX_PARITY_EN to insert an even parity bit       |
// |               between data bit 7 and the stop bit (11-bit frame).         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  wire  sys_clk,
  input  wire  sys_rst,
  uart_tx_byte_if.slave bus,
  output logic uart_tx
);

  // Counter reload value: a bit lasts from reload down to zero inclusive.
  localparam logic [15:0] C_RELOAD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [2:0]  idx_q,   idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q,    tx_d;
  logic        busy_q,  busy_d;
  logic        fin_q,   fin_d;
`ifdef UART_TX_PARITY_EN
  logic        par_q,   par_d;
`endif

  logic        bit_done;

  // The current bit period expires when the down-counter reaches zero.
  assign bit_done = (cnt_q == 16'd0);

  // State, timing and output registers; reset drives the line idle-high.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shreg_q <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic; the line value for each bit is registered on the
  // boundary edge that enters it, so uart_tx changes exactly on bit edges.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    fin_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.bus_data_flag) begin
          shreg_d = bus.bus_data;
`ifdef UART_TX_PARITY_EN
          par_d   = ^bus.bus_data;
`endif
          state_d = S_START;
          cnt_d   = C_RELOAD;
          idx_d   = 3'd0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          cnt_d   = C_RELOAD;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      S_DATA: begin
        if (bit_done) begin
          cnt_d = C_RELOAD;
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          cnt_d   = C_RELOAD;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif

      S_STOP: begin
        if (bit_done) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          fin_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
        idx_d   = 3'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign uart_tx             = tx_q;
  assign bus.busy            = busy_q;
  assign bus.bus_send_finish = fin_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_byte.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_byte                                              |
// | Description : Directed self-checking bench for uart_tx_byte at            |
// |               CLKS_PER_BIT=4; follows UART_TX_PARITY_EN if defined.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_byte;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CYC = NB * CPB;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  logic uart_tx;

  int checks   = 0;
  int failures = 0;

  uart_tx_byte_if bif ();

  uart_tx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bif),
    .uart_tx (uart_tx)
  );

  always #5 sys_clk = ~sys_clk;

  // Expected line sequence, first bit in bit 0. Parity value is supplied
  // by hand for each byte.
  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // Request a byte; returns right after the accepting edge E0.
  task automatic start_frame(input logic [7:0] d);
    @(negedge sys_clk);
    bif.bus_data      = d;
    bif.bus_data_flag = 1'b1;
    @(posedge sys_clk);
  endtask

  // Observe one frame cycle by cycle from E0 through the finish cycle.
  // Optionally injects a flag at cycle inj_j and chains a new byte in the
  // finish cycle.
  task automatic run_frame(input logic [7:0] d, input logic p, input string nm,
                           input int inj_j, input logic [7:0] inj_d,
                           input bit chain, input logic [7:0] chain_d);
    logic [10:0] fr;
    logic        exp_tx;
    int          fin;
    fr  = frame_of(d, p);
    fin = 0;
    for (int j = 0; j <= FRAME_CYC; j++) begin
      @(negedge sys_clk);
      bif.bus_data_flag = 1'b0;
      if (j == 0) bif.bus_data = ~d;
      if (j == inj_j) begin
        bif.bus_data_flag = 1'b1;
        bif.bus_data      = inj_d;
      end
      exp_tx = (j < FRAME_CYC) ? fr[j / CPB] : 1'b1;
      checks++;
      if (uart_tx !== exp_tx) begin
        failures++;
        $display("FAIL %s tx cyc=%0d got=%b exp=%b", nm, j, uart_tx, exp_tx);
      end
      checks++;
      if (bif.busy !== (j < FRAME_CYC)) begin
        failures++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b", nm, j, bif.busy, (j < FRAME_CYC));
      end
      checks++;
      if (bif.bus_send_finish !== (j == FRAME_CYC)) begin
        failures++;
        $display("FAIL %s finish cyc=%0d got=%b exp=%b", nm, j, bif.bus_send_finish, (j == FRAME_CYC));
      end
      if (bif.bus_send_finish === 1'b1) fin++;
      if (j == FRAME_CYC && chain) begin
        bif.bus_data_flag = 1'b1;
        bif.bus_data      = chain_d;
      end
    end
    checks++;
    if (fin !== 1) begin
      failures++;
      $display("FAIL %s finish_count got=%0d exp=1", nm, fin);
    end
  endtask

  task automatic test_reset();
    bif.bus_data      = 8'h00;
    bif.bus_data_flag = 1'b0;
    sys_rst           = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      checks++;
      if (uart_tx !== 1'b1 || bif.busy !== 1'b0 || bif.bus_send_finish !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold tx/busy/fin got=%b%b%b exp=100",
                 uart_tx, bif.busy, bif.bus_send_finish);
      end
    end
    sys_rst = 1'b1;
    repeat (20) begin
      @(negedge sys_clk);
      checks++;
      if (uart_tx !== 1'b1 || bif.busy !== 1'b0 || bif.bus_send_finish !== 1'b0) begin
        failures++;
        $display("FAIL idle tx/busy/fin got=%b%b%b exp=100",
                 uart_tx, bif.busy, bif.bus_send_finish);
      end
    end
  endtask

  task automatic test_frame_a5();
    start_frame(8'hA5);
    run_frame(8'hA5, 1'b0, "a5", -1, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_parity_one();
    start_frame(8'h01);
    run_frame(8'h01, 1'b1, "x01", -1, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    start_frame(8'h3C);
    run_frame(8'h3C, 1'b0, "b2b_3c", 7, 8'hFF, 1'b1, 8'h81);
    @(posedge sys_clk);
    run_frame(8'h81, 1'b0, "b2b_81", -1, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_reset_midframe();
    start_frame(8'h55);
    repeat (17) begin
      @(negedge sys_clk);
      bif.bus_data_flag = 1'b0;
    end
    checks++;
    if (bif.busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst busy_before got=%b exp=1", bif.busy);
    end
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || bif.busy !== 1'b0 || bif.bus_send_finish !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async tx/busy/fin got=%b%b%b exp=100",
               uart_tx, bif.busy, bif.bus_send_finish);
    end
    repeat (2) begin
      @(negedge sys_clk);
      checks++;
      if (uart_tx !== 1'b1 || bif.busy !== 1'b0 || bif.bus_send_finish !== 1'b0) begin
        failures++;
        $display("FAIL midrst_hold tx/busy/fin got=%b%b%b exp=100",
                 uart_tx, bif.busy, bif.bus_send_finish);
      end
    end
    sys_rst           = 1'b1;
    bif.bus_data      = 8'h0F;
    bif.bus_data_flag = 1'b1;
    @(posedge sys_clk);
    run_frame(8'h0F, 1'b0, "after_rst_0f", -1, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_parity_one();
    test_back_to_back();
    test_reset_midframe();
    repeat (5) @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_byte.md
UART_TX_BYTE -- requirements
Module: uart_tx_byte

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have port sys_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port sys_rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port bus_data, input, 8 bits: byte to transmit, valid when bus_data_flag is high.
REQ-005 The block SHALL have port bus_data_flag, input, 1 bit: single-cycle pulse requesting transmission of bus_data.
REQ-006 The block SHALL have port bus_send_finish, output, 1 bit: single-cycle pulse when a byte's stop bit has completed.
REQ-007 The block SHALL have port uart_tx, output, 1 bit: serial line, idle high.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-009 The block SHALL implement FSM states IDLE, START, DATA, PARITY (macro builds only), STOP.
REQ-010 In IDLE, a sampled bus_data_flag=1 SHALL latch bus_data into an 8-bit shift register and enter START on that edge (edge E0).
REQ-011 bus_data_flag SHALL be ignored in every state other than IDLE; bus_data is not sampled after E0.
REQ-012 uart_tx SHALL be driven from a register: 0 in START, the current data bit in DATA, the parity bit in PARITY, 1 in STOP and IDLE.
REQ-013 Each of START, each DATA bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a 16-bit down/up counter reloaded on every bit boundary.
REQ-014 Data bits SHALL be sent LSB first; a 3-bit index counts 0..7; DATA exits to PARITY/STOP after bit 7.
REQ-015 The STOP period SHALL end at edge E0 + 10*CLKS_PER_BIT (E0 + 11*CLKS_PER_BIT with parity), at which edge the FSM enters IDLE and bus_send_finish is set high for exactly one cycle.
REQ-016 busy SHALL be high from the cycle after E0 until the edge at which STOP ends; busy is low in the cycle bus_send_finish is high.
REQ-017 A bus_data_flag asserted in the same cycle bus_send_finish is high SHALL be accepted (back-to-back frames, no extra idle bit).
REQ-018 bus_send_finish SHALL never be asserted except at the end of STOP; exactly one finish per accepted byte.

Reset
REQ-019 sys_rst=0 SHALL, asynchronously and at any point including mid-frame, force state IDLE, uart_tx=1, busy=0, bus_send_finish=0, counters and shift register to 0.
REQ-020 After sys_rst deasserts, the block SHALL accept a bus_data_flag on the first rising edge.

Configuration
REQ-021 Macro UART_TX_PARITY_EN SHALL, when defined, insert a PARITY bit between bit 7 and STOP carrying even parity (XOR of the 8 data bits), giving an 11-bit frame.
REQ-022 Without UART_TX_PARITY_EN, the PARITY state and logic SHALL be absent and the frame SHALL be 10 bits (start, 8 data, stop).

Verification (CLKS_PER_BIT=4)
REQ-023 Reset then idle 20 cycles -> uart_tx=1, busy=0, bus_send_finish=0 throughout.
REQ-024 Pulse flag with 0xA5, no parity -> uart_tx per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; bus_send_finish pulse one cycle at E0+40; busy high 40 cycles.
REQ-025 Same with UART_TX_PARITY_EN, 0xA5 -> parity bit 0 before stop, finish at E0+44; 0x01 -> parity bit 1.
REQ-026 Flag 0x3C, then flag 0xFF at E0+8 (mid-frame), then flag 0x81 in the finish cycle -> 0x3C then 0x81 transmitted back-to-back, 0xFF never sent, two finish pulses.
REQ-027 Flag 0x55, drop sys_rst at E0+17 for 2 cycles -> uart_tx=1, busy=0 immediately, no finish pulse; new flag 0x0F after release is sent complete and correct.
